seq_divider: RTL

- Iterative restoring divider for the toy MIPS datapath. Supplies the DIV/DIVU result that the combinational ALU leaves unimplemented; it is the inverse operation of the multiplier slot.
- Accepts dividend/divisor with a start pulse, computes 1 quotient bit per cycle, and returns quotient (LO) and remainder (HI) with a done pulse.
- The control unit stalls on busy.

---
 rtl/seq_divider_if.sv | 38 +++
 rtl/seq_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle between the MIPS control unit and the iterative
// divider.
//   start     : request pulse, honoured only while busy is low
//   is_signed : 1 = DIV (two's complement), 0 = DIVU
//   A, B      : dividend / divisor, captured together with start
//   busy      : operation in flight, further starts are dropped
//   done      : one-cycle pulse, Q/R/flags valid
//   Q, R      : quotient (LO) and remainder (HI), held until next accept
//   div_zero  : last operation had B = 0
//   overflow  : last operation was signed MIN / -1
// master = requester side, slave = divider side.
// ----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, Q, R, div_zero, overflow
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, Q, R, div_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per clock. Signed operands
// are reduced to magnitudes at accept and the signs are re-applied in a final
// FIX cycle (quotient truncates toward zero, remainder follows the dividend).
// B = 0 and signed MIN / -1 bypass the iteration and complete one cycle after
// accept.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation silently
//   bus   : seq_divider_if.slave (start/is_signed/A/B in, busy/done/Q/R/
//           div_zero/overflow out, all outputs registered)
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_div_zero;
    logic             r_overflow;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_p;       // partial remainder
    logic [WIDTH-1:0] r_d;       // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] r_b;       // divisor magnitude
    logic             r_qsign;
    logic             r_rsign;
    logic             r_spec;    // special case pending completion (state stays IDLE)
    logic             r_spec_dz; // 1 = divide by zero, 0 = signed overflow

    logic             w_accept;
    logic             w_b_zero;
    logic             w_ovf_case;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_p_sub;

    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
    localparam logic [CW-1:0]    C_CNT1 = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement magnitude; MIN maps onto itself, which is correct read unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                               input logic          sgn);
        return (sgn && v[WIDTH-1]) ? f_neg(v) : v;
    endfunction

    // Accept decode, restoring trial subtraction and next-state selection.
    always_comb begin
        w_accept    = bus.start & ~r_busy;
        w_b_zero    = (bus.B == C_ZERO);
        w_ovf_case  = bus.is_signed & (bus.A == C_MIN) & (bus.B == C_ONES);
        w_shift     = {r_p, r_d[WIDTH-1]};
        // Trial P - |B| is non-negative exactly when the shifted value is >= |B|;
        // the difference is then < |B| so its low WIDTH bits are the new P.
        w_ge        = (w_shift >= {1'b0, r_b});
        w_p_sub     = w_shift[WIDTH-1:0] - r_b;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !r_spec && !w_b_zero && !w_ovf_case) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == C_CNT1) begin
                    w_state_nxt = S_FIX;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_q        <= C_ZERO;
            r_r        <= C_ZERO;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_p        <= C_ZERO;
            r_d        <= C_ZERO;
            r_b        <= C_ZERO;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_dz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_spec) begin
                        r_spec <= 1'b0;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        if (r_spec_dz) begin
                            r_q        <= C_ONES;
                            r_r        <= r_d;   // raw dividend parked here at accept
                            r_div_zero <= 1'b1;
                        end else begin
                            r_q        <= C_MIN;
                            r_r        <= C_ZERO;
                            r_overflow <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                        r_overflow <= 1'b0;
                        r_qsign    <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        r_rsign    <= bus.is_signed & bus.A[WIDTH-1];
                        r_b        <= f_mag(bus.B, bus.is_signed);
                        r_p        <= C_ZERO;
                        r_cnt      <= CW'(WIDTH);
                        r_spec     <= w_b_zero | w_ovf_case;
                        r_spec_dz  <= w_b_zero;
                        r_d        <= w_b_zero ? bus.A : f_mag(bus.A, bus.is_signed);
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_p   <= w_ge ? w_p_sub : w_shift[WIDTH-1:0];
                    r_d   <= {r_d[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - C_CNT1;
                end
                S_FIX: begin
                    r_q    <= r_qsign ? f_neg(r_d) : r_d;
                    r_r    <= (r_rsign && (r_p != C_ZERO)) ? f_neg(r_p) : r_p;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.Q        = r_q;
    assign bus.R        = r_r;
    assign bus.div_zero = r_div_zero;
    assign bus.overflow = r_overflow;

endmodule
